white_balance_pipe: RTL and testbench
=====================================

WHITE_BALANCE_PIPE -- requirements
Module: white_balance_pipe

Interface
REQ-001 SHALL have parameter CH_W, default 8, bits per colour channel.
REQ-002 SHALL have parameter NUM_CH, default 3, number of scaled colour channels.
REQ-003 SHALL have parameter FRAC_W, default 8, fractional bits of each gain; gain width G_W = CH_W+FRAC_W.
REQ-004 SHALL have parameter PASS_W, default 8, width of the unscaled upper field (alpha) passed through.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports ordered as below.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 white_valid  input  1  new white reference offered.
REQ-009 white_in  input  NUM_CH*CH_W  white reference; channel 0 in the LSBs.
REQ-010 white_ready  output  1  white reference accepted when white_valid and white_ready are both high.
REQ-011 in_valid  input  1  pixel offered.
REQ-012 in_data  input  PASS_W+NUM_CH*CH_W  pixel; {pass field, ch NUM_CH-1 .. ch 0}.
REQ-013 in_ready  output  1  pixel accepted when in_valid and in_ready are both high.
REQ-014 out_valid  output  1  out_data holds a valid pixel.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 out_data  output  PASS_W+NUM_CH*CH_W  balanced pixel, same field layout as in_data.
REQ-017 busy  output  1  high while gains are being recomputed.

Function
REQ-018 SHALL implement FSM states RUN and CALC; reset state is RUN.
REQ-019 SHALL hold one G_W-bit gain register per channel; reset value of each gain is unity (1<<FRAC_W).
REQ-020 white_ready SHALL be high only in RUN with both pipeline stages empty.
REQ-021 On a white handshake SHALL capture white_in and enter CALC on the next cycle.
REQ-022 CALC SHALL compute gain_c = floor(((2^CH_W-1)<<FRAC_W) / white_c) for c = 0..NUM_CH-1 in sequence.
- Uses a restoring divider, one quotient bit per cycle.
- Takes G_W cycles per channel, NUM_CH*G_W cycles in total (48 at defaults).
REQ-023 white_c = 0 SHALL yield gain_c = 2^G_W-1 with no divide-by-zero hazard.
REQ-024 Gains SHALL update atomically when CALC ends; the FSM SHALL then return to RUN.
REQ-025 busy SHALL be high in every CALC cycle and low otherwise.
REQ-026 in_ready SHALL be low in CALC, and in RUN SHALL equal (stage-1 can advance) AND NOT (white_valid AND white_ready).
- If a white reference and a pixel are offered together, the white reference wins.
REQ-027 The pixel path SHALL be two registered stages.
- Stage 1: one CH_W x G_W multiply per channel.
- Stage 2: shift right by FRAC_W, then saturate to 2^CH_W-1, with truncation (no rounding).
REQ-028 Latency SHALL be 2 cycles from input handshake to out_valid when out_ready stays high; throughput SHALL be 1 pixel/cycle.
REQ-029 The pass field SHALL travel alongside the pixel unchanged.
REQ-030 Each stage SHALL advance when it is empty or the stage after it advances; stage 2 advances on out_ready.
- A stalled stage holds its data and valid bit.
- No pixel is dropped or duplicated.
REQ-031 out_data SHALL stay stable while out_valid is high and out_ready is low.
REQ-032 Pixels accepted before a white handshake SHALL use the old gains; pixels accepted after CALC SHALL use the new gains.

Reset
REQ-033 rst SHALL force the following at the next clock edge:
- state RUN, all gains unity.
- out_valid=0, busy=0, out_data=0, pipeline valids 0.
REQ-034 rst asserted mid-CALC or with data in the pipeline SHALL abort all work; partial quotients and in-flight pixels are discarded.
REQ-035 After reset release, white_ready and in_ready SHALL be high in the first cycle (defaults).

Verification
REQ-036 Reset then stream in_data=0xAA102030 with out_ready=1 -> out_data=0xAA102030 two cycles later (unity gain).
REQ-037 White 0x80FFFF, so gain_ch2=510 and the others 256; then pixels ch2=100 and ch2=200 in.
- ch2=100 -> 199.
- ch2=200 -> 255 (saturated).
- busy high for exactly 48 cycles.
REQ-038 White 0x000000, then pixel 0x00010000 -> ch2=255, ch0=ch1=0.
REQ-039 Stream 8 pixels while out_ready toggles in a pseudo-random pattern -> all 8 arrive in order, unchanged, and out_data is stable during every stall.
REQ-040 Assert rst at CALC cycle 20 -> busy=0 and gains unity; the next pixel 0x00FFFFFF comes out as 0x00FFFFFF.
REQ-041 white_valid and in_valid offered in the same RUN cycle with the pipeline empty -> white accepted, in_ready=0; the pixel is accepted after CALC and uses the new gains.

Source files
------------

// File: rtl/white_balance_pipe.sv
// rtl/white_balance_pipe.sv - per-channel white-balance gain pipeline with serial gain divider
// Gains are recomputed from a white reference by a shared restoring divider
// (one quotient bit per cycle, channels in sequence), then applied to pixels
// through a two-stage multiply / shift-saturate pipeline with full backpressure.
module white_balance_pipe #(
   parameter int CH_W   = 8,
   parameter int NUM_CH = 3,
   parameter int FRAC_W = 8,
   parameter int PASS_W = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            white_valid,
   input  logic [NUM_CH*CH_W-1:0]          white_in,
   output logic                            white_ready,
   input  logic                            in_valid,
   input  logic [PASS_W+NUM_CH*CH_W-1:0]   in_data,
   output logic                            in_ready,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [PASS_W+NUM_CH*CH_W-1:0]   out_data,
   output logic                            busy
);

   localparam int G_W    = CH_W + FRAC_W;
   localparam int PIX_W  = NUM_CH * CH_W;
   localparam int DATA_W = PASS_W + PIX_W;
   localparam int P_W    = CH_W + G_W;
   localparam int BIT_CW = $clog2(G_W);
   localparam int CH_CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // Divider numerator: full-scale channel value in gain fixed point.
   localparam logic [G_W-1:0] DIV_NUM = {{CH_W{1'b1}}, {FRAC_W{1'b0}}};
   localparam logic [G_W-1:0] UNITY   = G_W'(1) << FRAC_W;

   typedef enum logic [0:0] {RUN, CALC} state_t;

   state_t                state_q, state_d;
   logic [PIX_W-1:0]      white_q, white_d;
   logic [G_W-1:0]        gain_q     [NUM_CH];
   logic [G_W-1:0]        gain_d     [NUM_CH];
   logic [G_W-1:0]        gain_new_q [NUM_CH];
   logic [G_W-1:0]        gain_new_d [NUM_CH];
   logic [G_W-1:0]        dq_q, dq_d;
   logic [CH_W-1:0]       rem_q, rem_d;
   logic [BIT_CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [CH_CW-1:0]      ch_cnt_q, ch_cnt_d;

   logic                  s1_valid_q, s1_valid_d;
   logic [P_W-1:0]        prod_q [NUM_CH];
   logic [P_W-1:0]        prod_d [NUM_CH];
   logic [PASS_W-1:0]     s1_pass_q, s1_pass_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_W-1:0]     out_data_q, out_data_d;

   logic [CH_W-1:0]       divisor;
   logic [CH_W:0]         rem_shift;
   logic [CH_W:0]         rem_sub;
   logic                  q_bit;
   logic [CH_W-1:0]       rem_next;
   logic [G_W-1:0]        dq_next;

   logic                  s2_adv;
   logic                  s1_adv;
   logic                  white_hs;
   logic                  in_hs;
   logic [PIX_W-1:0]      scaled;

   assign s2_adv      = !out_valid_q || out_ready;
   assign s1_adv      = !s1_valid_q || s2_adv;
   assign white_ready = (state_q == RUN) && !s1_valid_q && !out_valid_q;
   assign white_hs    = white_valid && white_ready;
   assign in_ready    = (state_q == RUN) && s1_adv && !white_hs;
   assign in_hs       = in_valid && in_ready;
   assign busy        = (state_q == CALC);
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;

   // One restoring-division step: a zero divisor always "fits", so the
   // quotient saturates to all ones without any special case.
   always_comb begin
      divisor = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_cnt_q == CH_CW'(c)) begin
            divisor = white_q[c*CH_W +: CH_W];
         end
      end
      rem_shift = {rem_q, dq_q[G_W-1]};
      q_bit     = (rem_shift >= {1'b0, divisor});
      rem_sub   = rem_shift - {1'b0, divisor};
      rem_next  = q_bit ? rem_sub[CH_W-1:0] : rem_shift[CH_W-1:0];
      dq_next   = {dq_q[G_W-2:0], q_bit};
   end

   // FSM next state, divider sequencing and atomic gain commit.
   always_comb begin
      state_d    = state_q;
      white_d    = white_q;
      gain_d     = gain_q;
      gain_new_d = gain_new_q;
      dq_d       = dq_q;
      rem_d      = rem_q;
      bit_cnt_d  = bit_cnt_q;
      ch_cnt_d   = ch_cnt_q;
      case (state_q)
         RUN: begin
            if (white_hs) begin
               white_d   = white_in;
               state_d   = CALC;
               dq_d      = DIV_NUM;
               rem_d     = '0;
               bit_cnt_d = '0;
               ch_cnt_d  = '0;
            end
         end
         CALC: begin
            dq_d      = dq_next;
            rem_d     = rem_next;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_CW'(G_W-1)) begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (ch_cnt_q == CH_CW'(c)) begin
                     gain_new_d[c] = dq_next;
                  end
               end
               dq_d      = DIV_NUM;
               rem_d     = '0;
               bit_cnt_d = '0;
               ch_cnt_d  = ch_cnt_q + 1'b1;
               if (ch_cnt_q == CH_CW'(NUM_CH-1)) begin
                  // Last channel finishes this cycle; all gains switch together.
                  for (int c = 0; c < NUM_CH; c++) begin
                     gain_d[c] = (c == NUM_CH-1) ? dq_next : gain_new_q[c];
                  end
                  ch_cnt_d = '0;
                  state_d  = RUN;
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Pixel pipeline: stage 1 multiplies, stage 2 drops the fraction and saturates.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      prod_d      = prod_q;
      s1_pass_d   = s1_pass_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      scaled      = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (|prod_q[c][P_W-1:FRAC_W+CH_W]) begin
            scaled[c*CH_W +: CH_W] = '1;
         end else begin
            scaled[c*CH_W +: CH_W] = prod_q[c][FRAC_W +: CH_W];
         end
      end
      if (s1_adv) begin
         s1_valid_d = in_hs;
         if (in_hs) begin
            for (int c = 0; c < NUM_CH; c++) begin
               prod_d[c] = P_W'(in_data[c*CH_W +: CH_W]) * P_W'(gain_q[c]);
            end
            s1_pass_d = in_data[DATA_W-1:PIX_W];
         end
      end
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = {s1_pass_q, scaled};
         end
      end
   end

   // State register with synchronous reset discarding all in-flight work.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         white_q     <= '0;
         dq_q        <= '0;
         rem_q       <= '0;
         bit_cnt_q   <= '0;
         ch_cnt_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_pass_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            gain_q[c]     <= UNITY;
            gain_new_q[c] <= UNITY;
            prod_q[c]     <= '0;
         end
      end else begin
         state_q     <= state_d;
         white_q     <= white_d;
         dq_q        <= dq_d;
         rem_q       <= rem_d;
         bit_cnt_q   <= bit_cnt_d;
         ch_cnt_q    <= ch_cnt_d;
         s1_valid_q  <= s1_valid_d;
         s1_pass_q   <= s1_pass_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         for (int c = 0; c < NUM_CH; c++) begin
            gain_q[c]     <= gain_d[c];
            gain_new_q[c] <= gain_new_d[c];
            prod_q[c]     <= prod_d[c];
         end
      end
   end

endmodule

// File: tb/tb_white_balance_pipe.sv
// tb/tb_white_balance_pipe.sv - self-checking bench for white_balance_pipe
module tb_white_balance_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        white_valid;
   logic [23:0] white_in;
   logic        white_ready;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        busy;

   white_balance_pipe dut (
      .clk         (clk),
      .rst         (rst),
      .white_valid (white_valid),
      .white_in    (white_in),
      .white_ready (white_ready),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] white;
      logic [31:0] pix;
      logic [31:0] exp;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   int          mg [3];
   logic [31:0] sbq [$];
   logic        stall = 1'b0;
   logic [31:0] held = '0;
   logic        rand_ready = 1'b0;
   vec_t        vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Reference: gain = full-scale / white (zero white -> max gain).
   task automatic model_set_gains(input logic [23:0] w);
      for (int c = 0; c < 3; c++) begin
         int wc;
         wc = int'(w[c*8 +: 8]);
         mg[c] = (wc == 0) ? 65535 : (255 * 256) / wc;
      end
   endtask

   function automatic logic [31:0] model_pix(input logic [31:0] d);
      logic [31:0] r;
      r = d;
      for (int c = 0; c < 3; c++) begin
         int v;
         v = (int'(d[c*8 +: 8]) * mg[c]) / 256;
         if (v > 255) v = 255;
         r[c*8 +: 8] = 8'(v);
      end
      return r;
   endfunction

   // Scoreboard: runs once per negedge from the single stimulus thread.
   task automatic monitor();
      logic [31:0] e;
      if (rst) begin
         sbq.delete();
         for (int c = 0; c < 3; c++) mg[c] = 256;
         stall = 1'b0;
         return;
      end
      if (stall) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", out_data, held);
      end
      if (out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_out", out_data, 32'hxxxxxxxx);
         end else begin
            e = sbq.pop_front();
            check("sb_out", out_data, e);
         end
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      if (white_valid && white_ready) model_set_gains(white_in);
      if (in_valid && in_ready) sbq.push_back(model_pix(in_data));
   endtask

   task automatic neg();
      @(negedge clk);
      monitor();
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic send_pixel(input logic [31:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         neg();
         if (in_ready) break;
         pos();
         n++;
         if (n > 500) begin
            fail_timeout("send_pixel");
            break;
         end
      end
      pos();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name, input logic [31:0] exp);
      int n;
      n = 0;
      forever begin
         neg();
         if (out_valid && out_ready) begin
            check(name, out_data, exp);
            break;
         end
         pos();
         n++;
         if (n > 50) begin
            fail_timeout(name);
            break;
         end
      end
      pos();
   endtask

   task automatic load_white(input logic [23:0] w);
      int n;
      int cnt;
      n = 0;
      cnt = 0;
      white_valid = 1'b1;
      white_in    = w;
      forever begin
         neg();
         if (white_ready) break;
         pos();
         n++;
         if (n > 500) begin
            fail_timeout("white_ready");
            break;
         end
      end
      pos();
      white_valid = 1'b0;
      forever begin
         neg();
         if (!busy) break;
         cnt++;
         pos();
         if (cnt > 200) break;
      end
      pos();
      check("busy_cycles", 32'(cnt), 32'd48);
   endtask

   initial begin
      int cnt;
      vecs[0] = '{24'h80FFFF, 32'h00640000, 32'h00C70000};
      vecs[1] = '{24'h80FFFF, 32'h00C80000, 32'h00FF0000};
      vecs[2] = '{24'h000000, 32'h00010000, 32'h00FF0000};
      vecs[3] = '{24'h000000, 32'h11010101, 32'h11FFFFFF};
      vecs[4] = '{24'h404040, 32'h55102030, 32'h553F7FBF};
      vecs[5] = '{24'hFFFFFF, 32'hAA102030, 32'hAA102030};
      vecs[6] = '{24'h0301FF, 32'h00010101, 32'h0055FF01};
      for (int c = 0; c < 3; c++) mg[c] = 256;

      rst = 1'b1;
      white_valid = 1'b0;
      white_in = '0;
      in_valid = 1'b0;
      in_data = '0;
      repeat (3) pos();
      neg();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      pos();
      rst = 1'b0;
      neg();
      check("rel_white_ready", 32'(white_ready), 32'd1);
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // Unity-gain latency: output appears on the second edge after handshake.
      pos();
      in_valid = 1'b1;
      in_data = 32'hAA102030;
      neg();
      pos();
      in_valid = 1'b0;
      neg();
      check("lat_early", 32'(out_valid), 32'd0);
      pos();
      neg();
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_data", out_data, 32'hAA102030);
      pos();

      for (int i = 0; i < 7; i++) begin
         load_white(vecs[i].white);
         send_pixel(vecs[i].pix);
         wait_out($sformatf("vec%0d", i), vecs[i].exp);
      end

      // White and pixel offered together: white wins, pixel waits for new gains.
      white_valid = 1'b1;
      white_in = 24'h80FFFF;
      in_valid = 1'b1;
      in_data = 32'h00640000;
      neg();
      check("simul_white_ready", 32'(white_ready), 32'd1);
      check("simul_in_ready", 32'(in_ready), 32'd0);
      pos();
      white_valid = 1'b0;
      cnt = 0;
      for (int n = 0; n < 200; n++) begin
         neg();
         if (busy) cnt++;
         if (in_ready) break;
         pos();
      end
      pos();
      in_valid = 1'b0;
      check("simul_busy", 32'(cnt), 32'd48);
      wait_out("simul_pix", 32'h00C70000);

      // Reset in the middle of a recompute.
      white_valid = 1'b1;
      white_in = 24'h000000;
      for (int n = 0; n < 50; n++) begin
         neg();
         if (white_ready) break;
         pos();
      end
      pos();
      white_valid = 1'b0;
      cnt = 0;
      for (int n = 0; n < 60; n++) begin
         neg();
         if (busy) cnt++;
         if (cnt == 20) break;
         pos();
      end
      check("midcalc_reached", 32'(cnt), 32'd20);
      pos();
      rst = 1'b1;
      neg();
      pos();
      rst = 1'b0;
      neg();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_white_ready", 32'(white_ready), 32'd1);
      pos();
      send_pixel(32'h00FFFFFF);
      wait_out("abort_unity", 32'h00FFFFFF);

      // Randomized traffic with backpressure; scoreboard checks every output.
      rand_ready = 1'b1;
      for (int b = 0; b < 6; b++) begin
         int np;
         if (b > 0) begin
            logic [23:0] w;
            w = 24'($urandom);
            if ($urandom_range(0, 3) == 0) w[8*$urandom_range(0, 2) +: 8] = 8'd0;
            load_white(w);
         end
         np = (b == 0) ? 8 : 20;
         for (int i = 0; i < np; i++) begin
            send_pixel($urandom);
            if ($urandom_range(0, 3) == 0) begin
               neg();
               pos();
            end
         end
      end
      for (int n = 0; n < 1000; n++) begin
         neg();
         if (sbq.size() == 0 && !out_valid) break;
         pos();
      end
      check("drain_empty", 32'(sbq.size()), 32'd0);
      pos();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
